// File: rtl/prime_pkg.sv
// Shared types and default sizing for the prime collector slice.
package prime_pkg;

  localparam int unsigned W_DEFAULT     = 32;
  localparam int unsigned DEPTH_DEFAULT = 8;
  localparam int unsigned CNT_W_DEFAULT = 16;

  // Sweep control states of the collector.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage : prime_pkg

// File: rtl/prime_fifo.sv
// Prime value FIFO with registered head; power-of-two depth, extra pointer MSB
// distinguishes full from empty. A push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module prime_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  input  logic         pop,
  output logic         head_valid,
  output logic [W-1:0] head_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_next;
  logic [PW-1:0] rd_next;
  logic          do_push;
  logic          do_pop;
  logic [W-1:0]  head_next;

  // Next pointers and the value that becomes the head after this edge.
  always_comb begin
    do_pop  = pop && head_valid;
    do_push = push && (!full || do_pop);
    wr_next = do_push ? wr_ptr + PW'(1) : wr_ptr;
    rd_next = do_pop  ? rd_ptr + PW'(1) : rd_ptr;
    // Bypass when the slot being written is the one that becomes the head.
    if (do_push && (rd_next[AW-1:0] == wr_ptr[AW-1:0])) begin
      head_next = push_data;
    end else begin
      head_next = mem[rd_next[AW-1:0]];
    end
  end

  // Storage write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointers, registered full/valid flags and registered head value.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      full       <= 1'b0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      wr_ptr     <= wr_next;
      rd_ptr     <= rd_next;
      full       <= (wr_next[AW] != rd_next[AW]) &&
                    (wr_next[AW-1:0] == rd_next[AW-1:0]);
      head_valid <= (wr_next != rd_next);
      if (wr_next != rd_next) begin
        head_data <= head_next;
      end
    end
  end

endmodule : prime_fifo

// File: rtl/prime_collector.sv
// Collects primes from a counter/is_prime stream into a FIFO and keeps
// per-sweep statistics, held for acknowledgement after the counter carry.
// Optional gap tracking: define PRIME_COLLECTOR_GAP_EN to enable max_gap.
module prime_collector
  import prime_pkg::*;
#(
  parameter int unsigned W     = W_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_cnt,
  input  logic             in_is_p,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             sum_valid,
  input  logic             sum_ack,
  output logic [CNT_W-1:0] prime_count,
  output logic [W-1:0]     last_prime,
  output logic [W-1:0]     max_gap,
  output logic             overflow
);

  state_t state_q;
  state_t state_d;
  logic   accept;
  logic   clear_stats;
  logic   fifo_full;
  logic   fifo_pop;
  logic   overflow_hit;

  // Sweep state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, sample acceptance and stats clear.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    clear_stats = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = in_is_p;
          state_d = in_carry ? HOLD : RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          accept = in_is_p;
          if (in_carry) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (sum_ack) begin
          clear_stats = 1'b1;
          state_d     = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Drop detection: full FIFO with no pop freeing a slot this cycle.
  always_comb begin
    fifo_pop     = out_valid && out_ready;
    overflow_hit = accept && fifo_full && !fifo_pop;
  end

  prime_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (accept),
    .push_data  (in_cnt),
    .full       (fifo_full),
    .pop        (fifo_pop),
    .head_valid (out_valid),
    .head_data  (out_data)
  );

  // Summary flag follows the state so it rises together with HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= (state_d == HOLD);
    end
  end

  // Prime count (saturating), last prime and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      prime_count <= '0;
      last_prime  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (clear_stats) begin
        prime_count <= '0;
        last_prime  <= '0;
      end else if (accept) begin
        if (prime_count != {CNT_W{1'b1}}) begin
          prime_count <= prime_count + CNT_W'(1);
        end
        last_prime <= in_cnt;
      end
      if (overflow_hit) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef PRIME_COLLECTOR_GAP_EN
  logic         have_prev;
  logic [W-1:0] gap;

  // Distance to the previous prime, modulo 2^W.
  always_comb begin
    gap = in_cnt - last_prime;
  end

  // Largest gap this sweep; the first prime of a sweep only arms have_prev.
  always_ff @(posedge clk) begin
    if (rst) begin
      have_prev <= 1'b0;
      max_gap   <= '0;
    end else if (clear_stats) begin
      have_prev <= 1'b0;
      max_gap   <= '0;
    end else if (accept) begin
      have_prev <= 1'b1;
      if (have_prev && (gap > max_gap)) begin
        max_gap <= gap;
      end
    end
  end
`else
  assign max_gap = '0;
`endif

endmodule : prime_collector

// File: tb/tb_prime_collector.sv
// Directed bench for prime_collector with a scoreboard queue of expected
// FIFO outputs and a small reference model of the sweep statistics.
module tb_prime_collector;
  import prime_pkg::*;

  localparam int unsigned DEPTH = 8;

`ifdef PRIME_COLLECTOR_GAP_EN
  localparam logic [31:0] GAP_EXP = 32'd10;
`else
  localparam logic [31:0] GAP_EXP = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_cnt;
  logic        in_is_p;
  logic        in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        sum_valid;
  logic        sum_ack;
  logic [15:0] prime_count;
  logic [31:0] last_prime;
  logic [31:0] max_gap;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q [$];
  state_t      m_state;
  logic [15:0] m_count;
  logic [31:0] m_last;
  logic [31:0] m_gap;
  logic        m_prev;
  logic        m_ovf;

  prime_collector dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_cnt      (in_cnt),
    .in_is_p     (in_is_p),
    .in_carry    (in_carry),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .sum_valid   (sum_valid),
    .sum_ack     (sum_ack),
    .prime_count (prime_count),
    .last_prime  (last_prime),
    .max_gap     (max_gap),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_state = IDLE;
    m_count = '0;
    m_last  = '0;
    m_gap   = '0;
    m_prev  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // One clock: scoreboard compare at negedge, model update, then drive point.
  task automatic cycle();
    logic        pop_m;
    logic        acc;
    logic [31:0] g;
    @(negedge clk);
    if (rst) begin
      model_reset();
    end else begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      pop_m = out_ready && (exp_q.size() > 0);
      if (pop_m) check("out_data", out_data, exp_q.pop_front());
      acc = in_valid && in_is_p && (m_state != HOLD);
      if (acc) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(in_cnt);
        else m_ovf = 1'b1;
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
`ifdef PRIME_COLLECTOR_GAP_EN
        if (m_prev) begin
          g = in_cnt - m_last;
          if (g > m_gap) m_gap = g;
        end
`else
        g = '0;
`endif
        m_prev = 1'b1;
        m_last = in_cnt;
      end
      case (m_state)
        IDLE: if (in_valid) m_state = in_carry ? HOLD : RUN;
        RUN:  if (in_valid && in_carry) m_state = HOLD;
        HOLD: if (sum_ack) begin
          m_state = RUN;
          m_count = '0;
          m_last  = '0;
          m_gap   = '0;
          m_prev  = 1'b0;
        end
        default: m_state = IDLE;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [31:0] cnt, input logic isp, input logic carry);
    in_valid = 1'b1;
    in_cnt   = cnt;
    in_is_p  = isp;
    in_carry = carry;
    cycle();
    in_valid = 1'b0;
    in_is_p  = 1'b0;
    in_carry = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_stats(input string tag);
    check({tag, ".prime_count"}, 32'(prime_count), 32'(m_count));
    check({tag, ".last_prime"},  last_prime, m_last);
    check({tag, ".max_gap"},     max_gap, m_gap);
    check({tag, ".overflow"},    32'(overflow), 32'(m_ovf));
    check({tag, ".sum_valid"},   32'(sum_valid), 32'(m_state == HOLD));
    check({tag, ".state"},       32'(dut.state_q), 32'(m_state));
  endtask

  task automatic ack();
    sum_ack = 1'b1;
    cycle();
    sum_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] ovf_primes [10];
    logic [31:0] full_primes [8];
    ovf_primes  = '{29, 31, 37, 41, 43, 47, 53, 59, 61, 67};
    full_primes = '{83, 89, 97, 101, 103, 107, 109, 113};

    rst = 1'b1; in_valid = 1'b0; in_cnt = '0; in_is_p = 1'b0;
    in_carry = 1'b0; out_ready = 1'b0; sum_ack = 1'b0;
    model_reset();
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;

    // Reset state.
    check("rst.out_valid",   32'(out_valid), 32'd0);
    check("rst.out_data",    out_data, 32'd0);
    check("rst.sum_valid",   32'(sum_valid), 32'd0);
    check("rst.prime_count", 32'(prime_count), 32'd0);
    check("rst.last_prime",  last_prime, 32'd0);
    check("rst.max_gap",     max_gap, 32'd0);
    check("rst.overflow",    32'(overflow), 32'd0);
    check("rst.state",       32'(dut.state_q), 32'(IDLE));

    // Sweep 0..10, carry on 10, primes drained immediately.
    out_ready = 1'b1;
    for (int i = 0; i <= 10; i++)
      step(32'(i), (i == 2) || (i == 3) || (i == 5) || (i == 7), i == 10);
    check("sweep1.prime_count", 32'(prime_count), 32'd4);
    check("sweep1.last_prime",  last_prime, 32'd7);
    check("sweep1.sum_valid",   32'(sum_valid), 32'd1);
    check_stats("sweep1");

    // Primes during HOLD are ignored.
    step(32'd11, 1'b1, 1'b0);
    step(32'd13, 1'b1, 1'b0);
    idle(2);
    check("hold.prime_count", 32'(prime_count), 32'd4);
    check("hold.out_valid",   32'(out_valid), 32'd0);
    check_stats("hold");

    // Acknowledge clears stats and resumes RUN.
    ack();
    check("ack.prime_count", 32'(prime_count), 32'd0);
    check("ack.sum_valid",   32'(sum_valid), 32'd0);
    check("ack.state",       32'(dut.state_q), 32'(RUN));
    check_stats("ack");

    // Gap sweep.
    step(32'd2, 1'b1, 1'b0);
    step(32'd3, 1'b1, 1'b0);
    step(32'd5, 1'b1, 1'b0);
    step(32'd7, 1'b1, 1'b0);
    step(32'd11, 1'b1, 1'b0);
    step(32'd13, 1'b1, 1'b0);
    step(32'd23, 1'b1, 1'b0);
    idle(2);
    check("gap.max_gap",     max_gap, GAP_EXP);
    check("gap.prime_count", 32'(prime_count), 32'd7);
    check("gap.last_prime",  last_prime, 32'd23);
    ack();
    check("ack_in_run.prime_count", 32'(prime_count), 32'd7);
    check_stats("ack_in_run");
    step(32'd24, 1'b0, 1'b1);
    ack();
    check_stats("gap_cleared");

    // Overflow: ten primes into an eight-entry FIFO with no consumer.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) step(ovf_primes[i], 1'b1, 1'b0);
    idle(1);
    check("ovf.overflow",    32'(overflow), 32'd1);
    check("ovf.prime_count", 32'(prime_count), 32'd10);
    check("ovf.out_valid",   32'(out_valid), 32'd1);
    check("ovf.out_data",    out_data, 32'd29);
    check_stats("ovf");
    out_ready = 1'b1;
    idle(9);
    check("ovf_drain.out_valid", 32'(out_valid), 32'd0);
    check("ovf_drain.sb_empty",  32'(exp_q.size()), 32'd0);

    // Reset mid-sweep with three entries queued.
    out_ready = 1'b0;
    step(32'd71, 1'b1, 1'b0);
    step(32'd73, 1'b1, 1'b0);
    step(32'd79, 1'b1, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst.out_valid",   32'(out_valid), 32'd0);
    check("mid_rst.out_data",    out_data, 32'd0);
    check("mid_rst.prime_count", 32'(prime_count), 32'd0);
    check("mid_rst.last_prime",  last_prime, 32'd0);
    check("mid_rst.max_gap",     max_gap, 32'd0);
    check("mid_rst.overflow",    32'(overflow), 32'd0);
    check("mid_rst.state",       32'(dut.state_q), 32'(IDLE));

    // Full FIFO with push and pop in the same cycle.
    for (int i = 0; i < 8; i++) step(full_primes[i], 1'b1, 1'b0);
    check("full.full", 32'(dut.u_fifo.full), 32'd1);
    out_ready = 1'b1;
    step(32'd127, 1'b1, 1'b0);
    out_ready = 1'b0;
    idle(1);
    check("pushpop.full",        32'(dut.u_fifo.full), 32'd1);
    check("pushpop.overflow",    32'(overflow), 32'd0);
    check("pushpop.prime_count", 32'(prime_count), 32'd9);
    check("pushpop.out_data",    out_data, 32'd89);
    check_stats("pushpop");
    out_ready = 1'b1;
    idle(10);
    check("pushpop_drain.out_valid", 32'(out_valid), 32'd0);
    check("pushpop_drain.sb_empty",  32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_prime_collector
